// File: rtl/tdm_demux.sv
// Three-stream TDM demultiplexer: tracks slot boundaries with a per-slot cycle
// counter, recovers DS1..DS3 words and flywheels on the configuration latched at frame start.
//
// state | meaning
// IDLE  | not tracking; waits for a frame_start with a valid configuration
// SLOT1 | receiving DS1 slot
// SLOT2 | receiving DS2 slot
// SLOT3 | receiving DS3 slot
module tdm_demux #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [2:0]        switch_clk_cycles,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] multiplexed_data,
  output logic [DATA_W-1:0] ds1_out,
  output logic [DATA_W-1:0] ds2_out,
  output logic [DATA_W-1:0] ds3_out,
  output logic [2:0]        ds_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SLOT1 = 2'd1,
    S_SLOT2 = 2'd2,
    S_SLOT3 = 2'd3
  } state_t;

  state_t            r_state;
  logic [2:0]        r_cyc;
  logic [1:0]        r_l_mode;
  logic [2:0]        r_l_n;
  logic [DATA_W-1:0] r_ds1;
  logic [DATA_W-1:0] r_ds2;
  logic [DATA_W-1:0] r_ds3;
  logic [2:0]        r_ds_valid;
  logic              r_frame_done;
  logic              r_sync_err;
  logic              r_locked;

  logic              w_cfg_ok;
  logic              w_fs_ok;
  logic              w_fs_bad;
  logic              w_aligned;
  logic              w_resync;
  state_t            w_state;
  logic [1:0]        w_slot;
  logic [2:0]        w_cyc;
  logic [1:0]        w_mode;
  logic [2:0]        w_n;
  logic              w_active;
  logic              w_last;
  logic              w_final;
  state_t            w_next_slot;

  assign w_cfg_ok  = (mode != 2'd0) && (switch_clk_cycles != 3'd0);
  assign w_fs_ok   = frame_start && w_cfg_ok;
  assign w_fs_bad  = frame_start && !w_cfg_ok;
  assign w_aligned = (r_state == S_SLOT1) && (r_cyc == 3'd0);
  assign w_resync  = w_fs_ok && r_locked && !w_aligned;

  // An accepted frame_start makes the current cycle cycle 0 of SLOT1 under the
  // freshly presented configuration, so position and config are overridden here.
  assign w_state = w_fs_ok ? S_SLOT1 : r_state;
  assign w_cyc   = w_fs_ok ? 3'd0 : r_cyc;
  assign w_mode  = w_fs_ok ? mode : r_l_mode;
  assign w_n     = w_fs_ok ? switch_clk_cycles : r_l_n;
  assign w_slot  = w_state;

  assign w_active    = (w_state != S_IDLE) && !w_fs_bad;
  assign w_last      = w_active && (w_cyc == (w_n - 3'd1));
  assign w_final     = w_last && (w_slot == w_mode);
  assign w_next_slot = (w_slot < w_mode) ? state_t'(w_slot + 2'd1) : S_SLOT1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cyc        <= 3'd0;
      r_l_mode     <= 2'd0;
      r_l_n        <= 3'd0;
      r_ds1        <= '0;
      r_ds2        <= '0;
      r_ds3        <= '0;
      r_ds_valid   <= 3'b000;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_ds_valid   <= 3'b000;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;

      if (frame_start) begin
        r_l_mode <= mode;
        r_l_n    <= switch_clk_cycles;
      end

      if (w_fs_bad) begin
        r_state  <= S_IDLE;
        r_cyc    <= 3'd0;
        r_locked <= 1'b0;
      end else if (w_active) begin
        if (w_fs_ok) begin
          r_locked <= 1'b1;
        end
        r_sync_err <= w_resync;
        if (w_last) begin
          case (w_state)
            S_SLOT1: begin
              r_ds1         <= multiplexed_data;
              r_ds_valid[0] <= 1'b1;
            end
            S_SLOT2: begin
              r_ds2         <= multiplexed_data;
              r_ds_valid[1] <= 1'b1;
            end
            S_SLOT3: begin
              r_ds3         <= multiplexed_data;
              r_ds_valid[2] <= 1'b1;
            end
            default: ;
          endcase
          r_frame_done <= w_final;
          r_cyc        <= 3'd0;
          r_state      <= w_next_slot;
        end else begin
          r_cyc   <= w_cyc + 3'd1;
          r_state <= w_state;
        end
      end
    end
  end

  assign ds1_out    = r_ds1;
  assign ds2_out    = r_ds2;
  assign ds3_out    = r_ds3;
  assign ds_valid   = r_ds_valid;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign locked     = r_locked;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: directed frames push expected output events,
// a negedge monitor pops and compares every pulse the DUT presents.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [2:0] switch_clk_cycles = 3'd0;
  logic       frame_start = 1'b0;
  logic [7:0] multiplexed_data = 8'h00;
  logic [7:0] ds1_out, ds2_out, ds3_out;
  logic [2:0] ds_valid;
  logic       frame_done, sync_err, locked;

  tdm_demux #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .switch_clk_cycles(switch_clk_cycles),
    .frame_start(frame_start), .multiplexed_data(multiplexed_data),
    .ds1_out(ds1_out), .ds2_out(ds2_out), .ds3_out(ds3_out),
    .ds_valid(ds_valid), .frame_done(frame_done), .sync_err(sync_err), .locked(locked)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    int         cyc;
    logic [2:0] v;
    logic       fd;
    logic       se;
    logic [7:0] d1, d2, d3;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  t0       = 0;
  bit  mon_en   = 1'b0;

  task automatic expect_ev(input int rel, input logic [2:0] v, input logic fd, input logic se,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    ev_t e;
    e.cyc = t0 + rel; e.v = v; e.fd = fd; e.se = se; e.d1 = a; e.d2 = b; e.d3 = c;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < edge_cnt) begin
        n_checks++; n_fail++;
        $display("FAIL missed_event: expected v=%b fd=%b se=%b at cycle %0d, nothing seen",
                 sb[0].v, sb[0].fd, sb[0].se, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (ds_valid !== 3'b000 || frame_done !== 1'b0 || sync_err !== 1'b0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: cycle %0d v=%b fd=%b se=%b, none expected",
                   edge_cnt, ds_valid, frame_done, sync_err);
        end else begin
          e = sb.pop_front();
          if (e.cyc != edge_cnt || ds_valid !== e.v || frame_done !== e.fd ||
              sync_err !== e.se || ds1_out !== e.d1 || ds2_out !== e.d2 ||
              ds3_out !== e.d3 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL event: got cyc=%0d v=%b fd=%b se=%b d=%h/%h/%h lk=%b, expected cyc=%0d v=%b fd=%b se=%b d=%h/%h/%h lk=1",
                     edge_cnt, ds_valid, frame_done, sync_err, ds1_out, ds2_out, ds3_out, locked,
                     e.cyc, e.v, e.fd, e.se, e.d1, e.d2, e.d3);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic fs, input logic [1:0] md, input logic [2:0] n, input logic [7:0] d);
    frame_start = fs; mode = md; switch_clk_cycles = n; multiplexed_data = d;
    @(posedge clk); #1;
  endtask

  task automatic end_test(input string name);
    rst = 1'b1;
    tick(1'b0, 2'd0, 3'd0, 8'h00);
    rst = 1'b0;
    repeat (3) tick(1'b0, 2'd0, 3'd0, 8'h00);
    check({"drain_", name}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] w2 [3];
    logic [7:0] w4 [9];
    logic [7:0] w6 [4];
    w2 = '{8'h11, 8'h22, 8'h33};
    w4 = '{8'h11, 8'h11, 8'h22, 8'h44, 8'h44, 8'h55, 8'h55, 8'h66, 8'h66};
    w6 = '{8'h11, 8'h11, 8'h22, 8'h22};

    rst = 1'b1;
    tick(1'b0, 2'd0, 3'd0, 8'h00);
    tick(1'b1, 2'd2, 3'd3, 8'hFF);
    check("reset_state", {ds1_out, ds2_out, ds3_out, ds_valid, frame_done, sync_err, locked}, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // mode 2, N=3, flywheel; mode/N inputs change mid-run without frame_start
    t0 = edge_cnt;
    expect_ev(3,  3'b001, 1'b0, 1'b0, 8'hA1, 8'h00, 8'h00);
    expect_ev(6,  3'b010, 1'b1, 1'b0, 8'hA1, 8'hB2, 8'h00);
    expect_ev(9,  3'b001, 1'b0, 1'b0, 8'hA1, 8'hB2, 8'h00);
    expect_ev(12, 3'b010, 1'b1, 1'b0, 8'hA1, 8'hB2, 8'h00);
    for (int t = 0; t < 13; t++) begin
      tick(t == 0, (t >= 4) ? 2'd3 : 2'd2, (t >= 4) ? 3'd5 : 3'd3,
           ((t / 3) % 2 == 0) ? 8'hA1 : 8'hB2);
      if (t == 0) check("locked_after_fs", 64'(locked), 64'd1);
    end
    end_test("m2n3");

    // mode 3, N=2
    t0 = edge_cnt;
    expect_ev(2, 3'b001, 1'b0, 1'b0, 8'h11, 8'h00, 8'h00);
    expect_ev(4, 3'b010, 1'b0, 1'b0, 8'h11, 8'h22, 8'h00);
    expect_ev(6, 3'b100, 1'b1, 1'b0, 8'h11, 8'h22, 8'h33);
    for (int t = 0; t < 7; t++) tick(t == 0, 2'd3, 3'd2, w2[(t / 2) % 3]);
    end_test("m3n2");

    // mode 1, N=6
    t0 = edge_cnt;
    expect_ev(6,  3'b001, 1'b1, 1'b0, 8'h5C, 8'h00, 8'h00);
    expect_ev(12, 3'b001, 1'b1, 1'b0, 8'h5C, 8'h00, 8'h00);
    expect_ev(18, 3'b001, 1'b1, 1'b0, 8'h5C, 8'h00, 8'h00);
    for (int t = 0; t < 19; t++) tick(t == 0, 2'd1, 3'd6, 8'h5C);
    check("m1_unused", {ds2_out, ds3_out}, 64'd0);
    end_test("m1n6");

    // mode 3, N=2 with a misaligned frame_start mid-SLOT2
    t0 = edge_cnt;
    expect_ev(2, 3'b001, 1'b0, 1'b0, 8'h11, 8'h00, 8'h00);
    expect_ev(4, 3'b000, 1'b0, 1'b1, 8'h11, 8'h00, 8'h00);
    expect_ev(5, 3'b001, 1'b0, 1'b0, 8'h44, 8'h00, 8'h00);
    expect_ev(7, 3'b010, 1'b0, 1'b0, 8'h44, 8'h55, 8'h00);
    expect_ev(9, 3'b100, 1'b1, 1'b0, 8'h44, 8'h55, 8'h66);
    for (int t = 0; t < 9; t++) tick(t == 0 || t == 3, 2'd3, 3'd2, w4[t]);
    end_test("resync");

    // mode 2, N=1 (capture every cycle), then frame_start with mode 0
    t0 = edge_cnt;
    expect_ev(1, 3'b001, 1'b0, 1'b0, 8'h70, 8'h00, 8'h00);
    expect_ev(2, 3'b010, 1'b1, 1'b0, 8'h70, 8'h71, 8'h00);
    expect_ev(3, 3'b001, 1'b0, 1'b0, 8'h72, 8'h71, 8'h00);
    expect_ev(4, 3'b010, 1'b1, 1'b0, 8'h72, 8'h73, 8'h00);
    for (int t = 0; t < 10; t++) begin
      tick(t == 0 || t == 4, (t == 4) ? 2'd0 : 2'd2, 3'd1, 8'h70 + 8'(t));
      if (t == 4) check("locked_drop", 64'(locked), 64'd0);
    end
    check("hold_after_invalid", {ds1_out, ds2_out}, {48'd0, 8'h72, 8'h73});
    end_test("invalid");

    // reset mid-frame, with frame_start during reset ignored
    t0 = edge_cnt;
    expect_ev(2, 3'b001, 1'b0, 1'b0, 8'h11, 8'h00, 8'h00);
    expect_ev(4, 3'b010, 1'b0, 1'b0, 8'h11, 8'h22, 8'h00);
    for (int t = 0; t < 4; t++) tick(t == 0, 2'd3, 3'd2, w6[t]);
    rst = 1'b1;
    tick(1'b1, 2'd3, 3'd2, 8'h33);
    rst = 1'b0;
    check("rst_mid_frame", {ds1_out, ds2_out, ds3_out, ds_valid, frame_done, sync_err, locked}, 64'd0);
    for (int t = 0; t < 8; t++) tick(1'b0, 2'd3, 3'd2, 8'h33);
    check("idle_no_capture", {ds1_out, locked}, 64'd0);
    end_test("rst_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer that sits directly downstream of the three-stream TDM multiplexer. It receives the 8-bit multiplexed word stream and a frame-start marker, and tracks slot boundaries with a per-slot cycle counter. It recovers up to three data streams (DS1..DS3) according to the active mode and presents each recovered word with a one-cycle valid pulse. Frame configuration is latched at frame start, so the block flywheels across frames and flags misaligned frame markers.

## Interface
- DATA_W, 8, width of multiplexed and recovered data words
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  2  channel count per frame: 1 = DS1 only, 2 = DS1,DS2, 3 = DS1,DS2,DS3; 0 invalid
- switch_clk_cycles  input  3  clk cycles each slot is held on the line (1..7); 0 invalid
- frame_start  input  1  high during the first cycle of slot 1 of a frame
- multiplexed_data  input  DATA_W  incoming TDM word stream
- ds1_out, ds2_out, ds3_out  output  DATA_W each  last recovered word per channel, held between updates
- ds_valid  output  3  bit k-1 pulses one cycle when dsk_out updates
- frame_done  output  1  one-cycle pulse when the last slot of a frame is captured
- sync_err  output  1  one-cycle pulse when frame_start arrives before the current frame completes
- locked  output  1  high while the demux is tracking frames with a valid latched configuration

## Operation
- States: IDLE, SLOT1, SLOT2, SLOT3. Registered slot cycle counter cyc, 3 bits.
- Latched config: on every accepted frame_start, latch mode and switch_clk_cycles as L_mode and L_N. Input changes at any other time are ignored.
- Accepting frame_start with invalid config (mode==0 or switch_clk_cycles==0):
  - Go to IDLE and clear locked.
  - Emit no valid, frame_done or sync_err pulses.
- Accepting frame_start with valid config:
  - That cycle is cycle 0 of SLOT1 and locked is set.
  - If L_N==1, the word is captured in that cycle. Otherwise cyc=1 on the next cycle.
- In SLOTk, cyc increments each cycle. In the cycle where cyc==L_N-1, multiplexed_data is captured:
  - dsk_out <= multiplexed_data.
  - ds_valid[k-1] pulses.
  - Then cyc <= 0 and the state moves to the next slot.
- Next slot after SLOTk is SLOT(k+1) if k<L_mode, else SLOT1 (wrap). Capture in SLOT(L_mode) also pulses frame_done.
- Flywheel: after wrap, the block continues with L_mode and L_N whether or not frame_start recurs.
- frame_start coinciding with cycle 0 of SLOT1 is aligned:
  - Re-latch config; no error.
- frame_start in any other cycle while locked is a resync:
  - Pulse sync_err and abandon the partial slot; no capture of that slot.
  - Restart at cycle 0 of SLOT1 with the newly latched config.
- IDLE: no captures. Leave IDLE only on frame_start with valid config.
- Unused channels hold their last value; their valid bits never pulse.

## Timing
- Reset (rst high at an edge): state IDLE, cyc 0, L_mode 0, L_N 0. All outputs 0: ds1/2/3_out, ds_valid, frame_done, sync_err, locked. Reset overrides frame_start in the same cycle.
- Capture latency: a word on the line in the last cycle of its slot appears on dsk_out, with its valid pulse, the following cycle (1 clk).
- frame_done is asserted in the same cycle as the final slot's ds_valid bit.
- sync_err is asserted the cycle after the offending frame_start, together with locked staying 1.
- Mode 1 with L_N=6: one capture every 6 cycles. Mode 2 with L_N=3: alternating DS1/DS2 captures every 3 cycles. Mode 3 with L_N=2: DS1/DS2/DS3 captures every 2 cycles.
- Reset mid-frame: the partial frame is discarded; no pulses in the cycle after reset.

## Test plan
- Mode 2, N=3, frame_start once, line carries 0xA1 x3 then 0xB2 x3 repeating -> ds1_out=0xA1 with ds_valid=001 at cycle 3, ds2_out=0xB2 with ds_valid=010 and frame_done at cycle 6, pattern repeats with no further frame_start (flywheel).
- Mode 3, N=2, words 0x11,0x22,0x33 each held 2 cycles -> valid bits 001,010,100 at cycles 2,4,6; frame_done at cycle 6; ds3_out=0x33.
- Mode 1, N=6, word 0x5C -> ds_valid=001 every 6 cycles, frame_done every 6 cycles, ds2_out/ds3_out stay 0x00.
- Mode 3, N=2, second frame_start at cycle 3 (mid-SLOT2) -> sync_err pulse at cycle 4, no DS2 capture, next capture is DS1 at cycle 5.
- frame_start with mode=0 while locked -> locked falls next cycle, no pulses thereafter. Changing mode from 2 to 3 mid-frame without frame_start -> captures keep 2-slot pattern.
- rst asserted at cycle 4 of a mode-3 frame -> next cycle all outputs 0, state IDLE; no captures until the next frame_start.
